serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller. It computes a - b - borrow_in by sequencing one 1-bit full-subtractor cell (diff = x^y^bin, borrow = (~x&y)|(~(x^y)&bin)) over WIDTH cycles, LSB first. An FSM with start/busy/done handshake controls the operand shift registers, the borrow flop and the result register. It serves as an area-minimal subtract engine for wide operands.

---
 rtl/serial_subtractor_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
//   Bit-serial subtractor: computes (a - b - borrow_in) mod 2^WIDTH, LSB first,
//   one bit per clock through a single full-subtractor cell.
//   Ports:
//     clk        - rising-edge clock
//     rst        - synchronous active-high reset (abandons any in-flight op)
//     start      - request; honoured only in IDLE or DONE
//     a, b       - minuend / subtrahend, captured when start is accepted
//     borrow_in  - initial borrow, captured when start is accepted
//     busy       - high while the operation is being sequenced (RUN)
//     done       - one-cycle pulse, diff/borrow_out just updated
//     diff       - registered difference, held until the next completion
//     borrow_out - registered final borrow, held with diff
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // Single full-subtractor cell working on the current LSBs.
  logic cx, cy, cd, cb;
  assign cx = sa_q[0];
  assign cy = sb_q[0];
  assign cd = cx ^ cy ^ brw_q;
  assign cb = (~cx & cy) | (~(cx ^ cy) & brw_q);

  // Partial result with the new bit shifted in at the MSB; after WIDTH
  // shifts the first (LSB) bit has reached position 0.
  logic [WIDTH-1:0] pr_shift;
  generate
    if (WIDTH == 1) begin : g_pr1
      assign pr_shift = cd;
    end else begin : g_prn
      assign pr_shift = {cd, pr_q[WIDTH-1:1]};
    end
  endgenerate

  logic last;
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    pr_d    = pr_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        pr_d  = pr_shift;
        brw_d = cb;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          diff_d  = pr_shift;
          bout_d  = cb;
          state_d = S_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE falls back to IDLE.
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          brw_d   = borrow_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      pr_q    <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      pr_q    <= pr_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8, bi8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  // WIDTH=1 instance
  logic       start1, a1, b1, bi1, busy1, done1, diff1, bo1;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .borrow_in(bi1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1));

  typedef struct packed {logic [7:0] d; logic b;} exp8_t;
  exp8_t      q8[$];
  logic [1:0] q1[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: pop expected result whenever the DUT pulses done.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done8: got done=1 expected no pending op at %0t", $time);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e.d));
        chk("bout8", 32'(bo8), 32'(e.b));
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done1: got done=1 expected no pending op at %0t", $time);
      end else begin
        logic [1:0] e;
        e = q1.pop_front();
        chk("diff1", 32'(diff1), 32'(e[1]));
        chk("bout1", 32'(bo1), 32'(e[0]));
      end
    end
  end

  // Issue one WIDTH=8 op and check busy window and done timing.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb);
    @(posedge clk); #1;
    a8 = a; b8 = b; bi8 = bi; start8 = 1'b1;
    q8.push_back('{d: ed, b: eb});
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy8_run", 32'(busy8), 32'd1);
      chk("done8_run", 32'(done8), 32'd0);
    end
    @(negedge clk);
    chk("done8_pulse", 32'(done8), 32'd1);
    chk("busy8_done", 32'(busy8), 32'd0);
  endtask

  task automatic op1(input logic [2:0] abc, input logic [1:0] exp);
    @(posedge clk); #1;
    {a1, b1, bi1} = abc; start1 = 1'b1;
    q1.push_back(exp);
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    chk("busy1_run", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("done1_pulse", 32'(done1), 32'd1);
  endtask

  // WIDTH=1 truth table, {a,b,bin} 000..111 -> {diff,borrow}
  logic [1:0] tt1 [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_diff8", 32'(diff8), 32'd0);
    chk("rst_bout8", 32'(bo8), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;

    // basic op and borrow cases
    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    op8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    op8(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);

    // WIDTH=1 full truth table
    for (int i = 0; i < 8; i++) op1(3'(i), tt1[i]);

    // start held through RUN: ignored, then accepted in DONE back-to-back
    @(posedge clk); #1;
    a8 = 8'h5A; b8 = 8'h3C; bi8 = 1'b0; start8 = 1'b1;
    q8.push_back('{d: 8'h1E, b: 1'b0});
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF;
    q8.push_back('{d: 8'h00, b: 1'b0});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_busy_a", 32'(busy8), 32'd1);
    end
    @(negedge clk);
    chk("b2b_done_a", 32'(done8), 32'd1);
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_busy_b", 32'(busy8), 32'd1);
    end
    @(negedge clk);
    chk("b2b_done_b", 32'(done8), 32'd1);

    // reset mid-RUN: abandoned, no done pulse afterwards
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h01; bi8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;           // accepted; RUN cycle 1
    start8 = 1'b0;
    repeat (3) @(posedge clk);    // now in RUN cycle 4
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_bout", 32'(bo8), 32'd0);
    repeat (12) @(negedge clk);   // any done here is flagged by the monitor
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

    // idle hold: outputs stable, no pulses
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_diff", 32'(diff8), 32'h7F);
      chk("hold_bout", 32'(bo8), 32'd0);
      chk("hold_done", 32'(done8), 32'd0);
      chk("hold_busy", 32'(busy8), 32'd0);
    end

    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
